alu: RTL and testbench

- Registered combinational ALU with parameterised width and eight operations selected by a 3-bit opcode.
- Takes two operands and a carry/borrow-in, and produces a result plus a carry/borrow/shift-out flag one clock later.
- Used as a leaf datapath block under a controller that drives the operands and opcode every cycle.

---
 rtl/alu_pkg.sv | 17 +
 rtl/alu_comb.sv | 69 ++++++
 rtl/alu.sv | 67 ++++++
 tb/tb_alu.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the alu datapath block.
package alu_pkg;

    localparam int ALU_OP_W = 3;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD = 3'b000,
        OP_SUB = 3'b001,
        OP_AND = 3'b010,
        OP_OR  = 3'b011,
        OP_XOR = 3'b100,
        OP_NOT = 3'b101,
        OP_SHL = 3'b110,
        OP_SHR = 3'b111
    } alu_op_e;

endpackage

// File: rtl/alu_comb.sv
// Combinational core of alu: next result and carry/borrow/shift-out flag
// computed from the operands, carry-in and opcode.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  alu_op_e          sel,
    output logic [WIDTH-1:0] result,
    output logic             cout
);

    logic [WIDTH:0] sum_s;
    logic [WIDTH:0] diff_s;

    // Add and subtract one bit wider so carry/borrow lands in the top bit.
    always_comb begin
        sum_s  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
        diff_s = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
    end

    // Opcode mux; logic ops and NOT report no carry.
    always_comb begin
        result = {WIDTH{1'b0}};
        cout   = 1'b0;
        case (sel)
            OP_ADD: begin
                result = sum_s[WIDTH-1:0];
                cout   = sum_s[WIDTH];
            end
            OP_SUB: begin
                result = diff_s[WIDTH-1:0];
                cout   = diff_s[WIDTH];
            end
            OP_AND: begin
                result = a & b;
                cout   = 1'b0;
            end
            OP_OR: begin
                result = a | b;
                cout   = 1'b0;
            end
            OP_XOR: begin
                result = a ^ b;
                cout   = 1'b0;
            end
            OP_NOT: begin
                result = ~a;
                cout   = 1'b0;
            end
            OP_SHL: begin
                result = {a[WIDTH-2:0], 1'b0};
                cout   = a[WIDTH-1];
            end
            OP_SHR: begin
                result = {1'b0, a[WIDTH-1:1]};
                cout   = a[0];
            end
            default: begin
                result = {WIDTH{1'b0}};
                cout   = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/alu.sv
// Registered ALU top: one-cycle latency over alu_comb, synchronous reset.
// Optional zero flag output built when ALU_ZERO_FLAG_EN is defined.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic                cin,
    input  logic [ALU_OP_W-1:0] sel,
    output logic [WIDTH-1:0]    result,
    output logic                cout
`ifdef ALU_ZERO_FLAG_EN
    ,
    output logic                zero
`endif
);

    logic [WIDTH-1:0] next_result_s;
    logic             next_cout_s;
    logic [WIDTH-1:0] result_r;
    logic             cout_r;

    alu_comb #(
        .WIDTH (WIDTH)
    ) u_comb (
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sel    (alu_op_e'(sel)),
        .result (next_result_s),
        .cout   (next_cout_s)
    );

    // Output registers; reset wins over whatever is on the inputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_r <= {WIDTH{1'b0}};
            cout_r   <= 1'b0;
        end else begin
            result_r <= next_result_s;
            cout_r   <= next_cout_s;
        end
    end

    assign result = result_r;
    assign cout   = cout_r;

`ifdef ALU_ZERO_FLAG_EN
    logic zero_r;

    // Zero flag tracks the registered result, so it resets to 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            zero_r <= 1'b1;
        end else begin
            zero_r <= ~|next_result_s;
        end
    end

    assign zero = zero_r;
`endif

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed plan plus randomized steps checked
// against an integer-arithmetic reference model.
module tb_alu;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [2:0]   sel;
    logic [W-1:0] result;
    logic         cout;
`ifdef ALU_ZERO_FLAG_EN
    logic         zero;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [W:0] exp_q;
    logic       have_prev = 1'b0;

    alu #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .cin    (cin),
        .sel    (sel),
        .result (result),
        .cout   (cout)
`ifdef ALU_ZERO_FLAG_EN
        ,
        .zero   (zero)
`endif
    );

    always #5 clk = ~clk;

    // Reference: {cout,result} from the opcode rules with plain integers.
    function automatic logic [W:0] ref_alu(input int av, input int bv, input int ci, input int op);
        int m;
        int t;
        int r;
        int c;
        m = 2 ** W;
        r = 0;
        c = 0;
        case (op)
            0: begin t = av + bv + ci; r = t % m; c = (t >= m) ? 1 : 0; end
            1: begin t = av - bv - ci; r = ((t % m) + m) % m; c = (av < bv + ci) ? 1 : 0; end
            2: r = av & bv;
            3: r = av | bv;
            4: r = av ^ bv;
            5: r = m - 1 - av;
            6: begin r = (av * 2) % m; c = av / (m / 2); end
            7: begin r = av / 2; c = av % 2; end
            default: r = 0;
        endcase
        return (W + 1)'(c * m + r);
    endfunction

    task automatic check(input string tag, input logic [W:0] got, input logic [W:0] expv);
        n_cmp++;
        assert (got === expv) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, got, expv);
        end
    endtask

    // Drive one cycle of inputs, confirm outputs still hold the previous
    // value before the edge, then confirm the new value after it.
    task automatic step(input string tag, input logic r, input logic [W-1:0] av,
                        input logic [W-1:0] bv, input logic ci, input logic [2:0] op);
        logic [W:0] e;
        rst = r;
        a   = av;
        b   = bv;
        cin = ci;
        sel = op;
        #1;
        if (have_prev) begin
            check({tag, "/hold"}, {cout, result}, exp_q);
        end
        if (r) begin
            e = {(W + 1){1'b0}};
        end else begin
            e = ref_alu(int'(av), int'(bv), int'(ci), int'(op));
        end
        @(posedge clk);
        #1;
        check(tag, {cout, result}, e);
`ifdef ALU_ZERO_FLAG_EN
        n_cmp++;
        assert (zero === (e[W-1:0] == {W{1'b0}})) else begin
            n_err++;
            $error("FAIL %s/zero: observed %b expected %b", tag, zero, (e[W-1:0] == {W{1'b0}}));
        end
`endif
        exp_q     = e;
        have_prev = 1'b1;
    endtask

    initial begin
        rst = 1'b1; a = 4'b0000; b = 4'b0000; cin = 1'b0; sel = 3'b000;
        exp_q = {(W + 1){1'b0}};

        step("reset0", 1'b1, 4'b1010, 4'b0101, 1'b0, 3'b000);
        step("reset1", 1'b1, 4'b1010, 4'b0101, 1'b0, 3'b000);

        // Opcode sweep with a mid-stream reset between OR and XOR
        for (int op = 0; op < 8; op++) begin
            step($sformatf("sweep_op%0d", op), 1'b0, 4'b1010, 4'b0101, 1'b0, 3'(op));
            if (op == 3) begin
                step("midreset", 1'b1, 4'b1010, 4'b0101, 1'b0, 3'b100);
            end
        end
        check("sweep_shr_const", {cout, result}, 5'b0_0101);

        step("add_max", 1'b0, 4'b1111, 4'b1111, 1'b1, 3'b000);
        check("add_max_const", {cout, result}, 5'b1_1111);
        step("add_wrap0", 1'b0, 4'b1000, 4'b1000, 1'b0, 3'b000);
        check("add_wrap0_const", {cout, result}, 5'b1_0000);
        step("sub_borrow", 1'b0, 4'b0011, 4'b0101, 1'b0, 3'b001);
        check("sub_borrow_const", {cout, result}, 5'b1_1110);
        step("sub_zero_cin", 1'b0, 4'b0000, 4'b0000, 1'b1, 3'b001);
        check("sub_zero_cin_const", {cout, result}, 5'b1_1111);
        step("and_cin_ign", 1'b0, 4'b1100, 4'b1010, 1'b1, 3'b010);
        check("and_cin_ign_const", {cout, result}, 5'b0_1000);

        // Randomized back-to-back operations with occasional reset
        for (int i = 0; i < 300; i++) begin
            step($sformatf("rand%0d", i), ($urandom_range(0, 19) == 0) ? 1'b1 : 1'b0,
                 W'($urandom), W'($urandom), 1'($urandom), 3'($urandom_range(0, 7)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
